// File: rtl/sr_stack.sv
// sr_stack: exception-path status register.
// Holds a DEPTH-level stack of {s_u, ie} mode pairs. An exception pushes the stack and an rfe
// pops it. Also holds a software-writable interrupt mask, a nesting counter with a sticky
// overflow flag, and a registered interrupt request. Software gets a 32-bit read/write view.
module sr_stack #(
  parameter int unsigned DEPTH = 3,  // 2..8 mode-stack levels
  parameter int unsigned INT_W = 6   // 1..8 interrupt lines
) (
  input  logic             clk,
  input  logic             rst,        // synchronous, active-low
  input  logic             exception,
  input  logic             rfe,
  input  logic             sr_we,
  input  logic [31:0]      sr_wdata,
  input  logic [INT_W-1:0] int_pend,
  output logic [31:0]      sr_rdata,
  output logic             IE_c,
  output logic             s_u_c,
  output logic             irq,
  output logic             nest_ovf
);

  localparam int         NumLvl = int'(DEPTH);
  localparam logic [3:0] CntMax = 4'(DEPTH - 1);

  // Level 0 is the current mode, level 1 the previous one, and so on.
  logic [1:0]       r_entry [DEPTH];
  logic [1:0]       w_entry_d [DEPTH];
  logic [INT_W-1:0] r_im;
  logic [INT_W-1:0] w_im_d;
  logic [3:0]       r_cnt;
  logic [3:0]       w_cnt_d;
  logic             r_ovf;
  logic             w_ovf_d;
  logic             r_irq;
  logic             w_irq_d;

  // Bits of the write word that map to no field; folded here so none of them dangle.
  logic             w_unused_wdata;
  assign w_unused_wdata = ^sr_wdata;

  // Next state. Only the highest-priority event acts: exception, then rfe, then sr_we.
  always_comb begin
    w_entry_d = r_entry;
    w_im_d    = r_im;
    w_cnt_d   = r_cnt;
    w_ovf_d   = r_ovf;
    if (exception) begin
      for (int k = NumLvl - 1; k > 0; k--) begin
        w_entry_d[k] = r_entry[k-1];
      end
      w_entry_d[0] = 2'b00;
      // The count saturates at the deepest level; further nesting only sets the sticky flag.
      if (r_cnt == CntMax) begin
        w_ovf_d = 1'b1;
      end else begin
        w_cnt_d = r_cnt + 4'd1;
      end
    end else if (rfe) begin
      for (int k = 0; k < NumLvl - 1; k++) begin
        w_entry_d[k] = r_entry[k+1];
      end
      w_entry_d[NumLvl-1] = 2'b00;
      // A pop at zero depth still shifts the stack but leaves the count at zero.
      if (r_cnt != 4'd0) begin
        w_cnt_d = r_cnt - 4'd1;
      end
    end else if (sr_we) begin
      for (int k = 0; k < NumLvl; k++) begin
        w_entry_d[k] = sr_wdata[2*k +: 2];
      end
      w_im_d = sr_wdata[16 +: INT_W];
      // The overflow flag is write-1-to-clear. The count is read-only.
      if (sr_wdata[31]) begin
        w_ovf_d = 1'b0;
      end
    end
  end

  // Interrupt request uses the pre-edge enable and mask, so it lags their changes by one cycle.
  always_comb begin
    w_irq_d = r_entry[0][0] & (|(int_pend & r_im));
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < NumLvl; k++) begin
        r_entry[k] <= (k == 0) ? 2'b11 : 2'b00;
      end
      r_im  <= '0;
      r_cnt <= 4'd0;
      r_ovf <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      r_entry <= w_entry_d;
      r_im    <= w_im_d;
      r_cnt   <= w_cnt_d;
      r_ovf   <= w_ovf_d;
      r_irq   <= w_irq_d;
    end
  end

  // Read view assembled from state only; unmapped bits read as zero.
  always_comb begin
    sr_rdata = '0;
    for (int k = 0; k < NumLvl; k++) begin
      sr_rdata[2*k +: 2] = r_entry[k];
    end
    sr_rdata[16 +: INT_W] = r_im;
    sr_rdata[27:24]       = r_cnt;
    sr_rdata[31]          = r_ovf;
  end

  assign IE_c     = r_entry[0][0];
  assign s_u_c    = r_entry[0][1];
  assign irq      = r_irq;
  assign nest_ovf = r_ovf;

endmodule
